// File: rtl/queue_param.sv
// queue_param: parametrised single-clock FIFO with separate write and read
// ports, occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
//
// Build option: define QUEUE_FWFT_EN for first-word-fall-through reads
// (rd_data shows the head word combinationally, rd_valid = !empty).
// Without it, a read loads rd_data on the accepting edge and rd_valid
// pulses for one cycle.

module queue_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int AF_LEVEL = 2**ADDR_W - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              err_clr,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR  = (ADDR_W+1)'(AE_LEVEL);

    // Storage is deliberately left out of reset so it can map to RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0] count_reg, count_next;
    logic            empty_reg, empty_next;
    logic            full_reg, full_next;
    logic            almost_empty_reg, almost_empty_next;
    logic            almost_full_reg, almost_full_next;
    logic            overflow_reg, overflow_next;
    logic            underflow_reg, underflow_next;

    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] head_word;

    // Acceptance is decided from the registered flags of the current cycle,
    // so a write into a full queue is refused even if a read frees a slot.
    assign wr_accept = wr_en && !full_reg;
    assign rd_accept = rd_en && !empty_reg;
    assign head_word = mem[rd_ptr_reg[ADDR_W-1:0]];

    // Next pointers and every status flag derived from the post-update pointers.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end

        count_next        = wr_ptr_next - rd_ptr_next;
        empty_next        = (wr_ptr_next == rd_ptr_next);
        full_next         = (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]) &&
                            (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]);
        almost_empty_next = (count_next <= AE_THR);
        almost_full_next  = (count_next >= AF_THR);

        // Sticky errors: a new error in the same cycle as err_clr wins.
        overflow_next = overflow_reg;
        if (wr_en && full_reg) begin
            overflow_next = 1'b1;
        end else if (err_clr) begin
            overflow_next = 1'b0;
        end

        underflow_next = underflow_reg;
        if (rd_en && empty_reg) begin
            underflow_next = 1'b1;
        end else if (err_clr) begin
            underflow_next = 1'b0;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            empty_reg        <= 1'b1;
            full_reg         <= 1'b0;
            almost_empty_reg <= 1'b1;
            almost_full_reg  <= 1'b0;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            empty_reg        <= empty_next;
            full_reg         <= full_next;
            almost_empty_reg <= almost_empty_next;
            almost_full_reg  <= almost_full_next;
            overflow_reg     <= overflow_next;
            underflow_reg    <= underflow_next;
        end
    end

    // Storage write on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
    end

`ifdef QUEUE_FWFT_EN
    // Head word falls through; rd_en simply pops it.
    assign rd_data  = head_word;
    assign rd_valid = !empty_reg;
`else
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    // Registered read: capture the head on an accepted read, flag it for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_reg <= head_word;
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
`endif

    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_empty = almost_empty_reg;
    assign almost_full  = almost_full_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_queue_param.sv
// tb_queue_param: randomized checks of queue_param (depth 16) against a
// queue-based reference model. Honours QUEUE_FWFT_EN for read-side
// expectations.

module tb_queue_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;
    localparam int AE_LVL = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              err_clr = 1'b0;
    logic              empty, full, almost_empty, almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow, underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_udf = 1'b0;
    logic       exp_rv  = 1'b0;
    logic [7:0] exp_rd  = 8'h00;

    queue_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .AF_LEVEL(AF_LVL),
        .AE_LEVEL(AE_LVL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .err_clr     (err_clr),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check_eq("count", 32'(count), 32'(sz));
        check_eq("empty", 32'(empty), 32'(sz == 0));
        check_eq("full", 32'(full), 32'(sz == DEPTH));
        check_eq("almost_empty", 32'(almost_empty), 32'(sz <= AE_LVL));
        check_eq("almost_full", 32'(almost_full), 32'(sz >= AF_LVL));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("underflow", 32'(underflow), 32'(exp_udf));
`ifdef QUEUE_FWFT_EN
        check_eq("rd_valid", 32'(rd_valid), 32'(sz != 0));
        if (sz != 0) begin
            check_eq("rd_data", 32'(rd_data), 32'(q[0]));
        end
`else
        check_eq("rd_valid", 32'(rd_valid), 32'(exp_rv));
        check_eq("rd_data", 32'(rd_data), 32'(exp_rd));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        exp_rv  = 1'b0;
        exp_rd  = 8'h00;
    endtask

    // One clock cycle of stimulus, then model update and full comparison.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ec);
        int  n;
        logic wacc, racc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = ec;
        @(posedge clk);
        #1;
        n    = q.size();
        wacc = we && (n < DEPTH);
        racc = re && (n > 0);
        exp_rv = racc;
        if (racc) exp_rd = q.pop_front();
        if (wacc) q.push_back(wd);
        if (we && !wacc) exp_ovf = 1'b1;
        else if (ec)     exp_ovf = 1'b0;
        if (re && !racc) exp_udf = 1'b1;
        else if (ec)     exp_udf = 1'b0;
        check_all();
        $display("txn t=%0t we=%0b wd=%02h re=%0b ec=%0b count=%0d rd=%02h rv=%0b ovf=%0b udf=%0b",
                 $time, we, wd, re, ec, count, rd_data, rd_valid, overflow, underflow);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        // Reset and idle
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill with 0x01..0x10, then drain in order
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow: fill, push 0xAA alone and together with a read, then clear
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow, write+read on empty, set-wins against err_clr, clear
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Hold at 8 across pointer wrap, then climb through almost_full
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Single word into an empty queue
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h3E, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/queue_param.md
# queue_param

Parametrised synchronous FIFO queue: next generation of the team's single-port queue. It has separate write and read data ports instead of a shared bidirectional bus, and supports a read and a write in the same cycle. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain.

## Interface
- `DATA_W`, 8: data word width in bits.
- `ADDR_W`, 10: address width; depth = 2**ADDR_W entries.
- `AF_LEVEL`, 2**ADDR_W-4: `almost_full` asserts when count >= AF_LEVEL.
- `AE_LEVEL`, 4: `almost_empty` asserts when count <= AE_LEVEL.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_W  write data; sampled when a write is accepted.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_W  read data.
- `rd_valid`  out  1  `rd_data` holds a newly read word (standard mode only; see Configuration).
- `err_clr`  in  1  synchronous clear of `overflow` and `underflow`.
- `empty`, `full`, `almost_empty`, `almost_full`  out  1 each  status flags.
- `count`  out  ADDR_W+1  number of stored words, 0..2**ADDR_W.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- Storage is an array of 2**ADDR_W x DATA_W words with asynchronous read. Contents are not cleared by reset.
- Write and read pointers are ADDR_W+1 bits wide. The low ADDR_W bits address storage; the MSB is the wrap bit.
- Both pointers increment modulo 2**(ADDR_W+1).
- Empty condition: pointers are equal. Full condition: addresses are equal and wrap bits differ.
- Write accepted = `wr_en` && !`full`. On accept, storage at wr_ptr is written with `wr_data` and wr_ptr increments.
- Read accepted = `rd_en` && !`empty`. On accept, rd_ptr increments.
- Simultaneous accepted read and write: both pointers advance and `count` is unchanged.
- Write while full: rejected, storage unchanged, `overflow` is set. This holds even if a read is accepted in the same cycle.
- Read while empty: rejected, `underflow` is set. A write in the same cycle is still accepted.
- `count` = wr_ptr - rd_ptr, computed modulo 2**(ADDR_W+1).
- All flags are registered and derived from the post-update pointers.
- `overflow` and `underflow` stay set until `err_clr` or reset. If `err_clr` and a new error occur in the same cycle, the flag is set (set wins).
- Reset mid-operation: all pointers, flags and outputs return to reset values on the next reset assertion. Queued data is discarded.

## Timing
- Reset values:
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0
  - `count`=0, `overflow`=0, `underflow`=0
  - `rd_data`=0, `rd_valid`=0
- A write accepted at edge N is reflected in `count` and flags after edge N. `empty` falls in cycle N+1.
- Standard mode: a read accepted at edge N loads `rd_data` at edge N and pulses `rd_valid` high for cycle N+1 only. `rd_data` holds its value otherwise.
- Write-to-read latency (empty queue, standard mode): `wr_en` at edge N; earliest accepted `rd_en` at edge N+1; data visible in cycle N+2.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- `QUEUE_FWFT_EN` defined (first-word-fall-through):
  - `rd_data` is driven combinationally from storage at rd_ptr and is valid whenever `empty`=0.
  - `rd_en` acknowledges and pops the current head word.
  - `rd_valid` is tied to !`empty`.
  - Write-to-visible latency is one cycle: the word written at edge N appears on `rd_data` in cycle N+1.
- `QUEUE_FWFT_EN` undefined: standard registered-read behaviour as described above.

## Test plan
- Reset then idle: `empty`=1, `count`=0, `almost_empty`=1, `rd_valid`=0, all other flags 0.
- Write 0x01..0x10 (ADDR_W=4, depth 16) then read 16 times:
  - after the writes, `full`=1 and `count`=16;
  - reads return 0x01..0x10 in order, each with a one-cycle `rd_valid`;
  - `empty`=1 at the end.
- Fill to full, then assert `wr_en` with 0xAA:
  - `overflow`=1, `count` stays 16, and 0xAA is never read back;
  - pulse `err_clr`: `overflow`=0.
- Read while empty: `underflow`=1 and `count`=0. Then assert `wr_en` and `rd_en` together on the empty queue: the write is accepted, `count`=1, `underflow` stays 1.
- Hold at count 8, then run 40 cycles of simultaneous read/write across pointer wrap:
  - `count` stays 8;
  - data order is preserved;
  - `almost_full` asserts exactly at count 12 (AF_LEVEL=12).
- With `QUEUE_FWFT_EN`: write 0x5C into the empty queue.
  - `rd_data`=0x5C in the next cycle with no `rd_en`.
  - Then assert reset mid-stream: `empty`=1 and `count`=0 immediately.
